riscv_trace_buffer: RTL and testbench
=====================================

# riscv_trace_buffer

Captures per-cycle retirement activity from the riscv core's debug outputs: register-file writes and data-memory reads/writes. Each cycle with activity becomes one timestamped trace record. Records are buffered in a FIFO and drained by a downstream consumer over a valid/ready handshake. The block sits beside the core, at the consuming end of its debug ports, and feeds a UART or JTAG dump path.

## Interface
Parameters:
- DATA_W, 32, width of register and memory data fields
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- STAMP_W, 16, timestamp counter width
- Record width REC_W = STAMP_W + 3 + 5 + 9 + 2·DATA_W (97 at defaults)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  capture enable; the drain side is unaffected
- clr_stats  in  1  clears drop_count and overflow
- reg_write_sig  in  1  core register-write strobe
- reg_num  in  5  destination register
- reg_data  in  DATA_W  register write data
- wr  in  1  core memory write strobe
- rd  in  1  core memory read strobe
- addr  in  9  memory address
- wr_data  in  DATA_W  memory write data
- rd_data  in  DATA_W  memory read data
- trace_valid  out  1  trace_data holds a record
- trace_ready  in  1  consumer accepts the record
- trace_data  out  REC_W  head record
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_count  out  16  records lost to overflow, saturating
- overflow  out  1  sticky; set when any record is dropped

## Operation
- Event detection, evaluated each cycle:
  - rw = reg_write_sig && reg_num != 0; writes to x0 are ignored.
  - mw = wr.
  - mr = rd.
  - A record is generated when enable && (rw || mw || mr).
- Record layout, MSB to LSB: stamp[STAMP_W], rw, mw, mr, reg_num[5], addr[9], reg_data[DATA_W], mem_data[DATA_W].
- Field rules:
  - reg_num and reg_data are zero when rw = 0.
  - addr and mem_data are zero when mw = mr = 0.
  - mem_data = wr_data if mw, else rd_data. If wr and rd are both high, both flags are set and mem_data takes wr_data.
- Timestamp: a free-running STAMP_W counter. It reads 0 in the first cycle after reset, increments every cycle regardless of enable, and wraps at 2^STAMP_W−1 → 0. A record carries the stamp of its capture cycle.
- FIFO: circular buffer with read/write pointers and occupancy count. trace_data is the head entry (first-word-fall-through). trace_valid = (count != 0).
  - A pop occurs on trace_valid && trace_ready.
  - A push occurs when a record is generated and either count < DEPTH or a pop occurs in the same cycle.
- Full-buffer handling:
  - Full, with a record generated and no pop: the record is dropped, drop_count increments (saturating at 0xFFFF), and overflow is set.
  - Full, with a push and a pop in the same cycle: the push is accepted and count stays at DEPTH.
- Empty with push and pop together: impossible, because trace_valid = 0 when empty.
- clr_stats has priority over a same-cycle drop: the counter clears to 0 and overflow to 0.
- trace_data and trace_valid must stay stable while trace_valid && !trace_ready.

## Timing
- Reset values: trace_valid 0, count 0, drop_count 0, overflow 0, timestamp 0, pointers 0. trace_data is don't-care but must be driven to 0.
- Reset mid-operation discards all buffered records and resets statistics on the next edge.
- Capture-to-output latency is 1 cycle. A record generated in cycle N into an empty FIFO gives trace_valid = 1 in cycle N+1.
- Throughput is one record per cycle in and one per cycle out. Pointer wrap at DEPTH−1 → 0 is seamless.
- count updates on the same edge as push or pop: +1 on push only, −1 on pop only, unchanged on both.
- No combinational path from trace_ready to trace_valid or trace_data.

## Test plan
- Reset, then a single event reg_write_sig=1, reg_num=5, reg_data=0xDEADBEEF in stamp cycle 3 → next cycle trace_valid=1; trace_data has stamp=3, rw=1, mw=mr=0, reg_num=5, reg_data=0xDEADBEEF, and all other fields 0.
- reg_write_sig=1 with reg_num=0, and no memory strobe → no record; count stays 0.
- Same-cycle rw (x7=0x11) and wr to addr 0x1A0 with wr_data 0x22 → one record with rw=1, mw=1, reg_num=7, addr=0x1A0, mem_data=0x22.
- trace_ready=0; 20 consecutive events at DEPTH=16 → count=16, drop_count=4, overflow=1. Draining then returns stamps in capture order for the first 16 events. A subsequent clr_stats pulse → drop_count=0, overflow=0.
- Full FIFO, trace_ready=1, one event per cycle for 40 cycles → count held at 16, drop_count unchanged, output stamps strictly consecutive with no gaps. Run across pointer wrap and the timestamp wrap 0xFFFF → 0x0000.
- Assert reset with 9 entries buffered → next cycle count=0, trace_valid=0, drop_count=0, and the stamp restarts at 0.

Source files
------------

// File: rtl/riscv_trace_buffer.sv
// Timestamped trace capture of riscv register-file and data-memory activity,
// buffered in a first-word-fall-through FIFO with a valid/ready drain port.
module riscv_trace_buffer #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16,
    localparam int REC_W  = STAMP_W + 3 + 5 + 9 + 2 * DATA_W,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clr_stats,
    input  logic              reg_write_sig,
    input  logic [4:0]        reg_num,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              wr,
    input  logic              rd,
    input  logic [8:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [REC_W-1:0]  trace_data,
    output logic [CW-1:0]     count,
    output logic [15:0]       drop_count,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [STAMP_W-1:0] stamp;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [REC_W-1:0]   mem [DEPTH];

    logic              rw;
    logic              mw;
    logic              mr;
    logic              gen;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [4:0]        rec_rnum;
    logic [8:0]        rec_addr;
    logic [DATA_W-1:0] rec_rdata;
    logic [DATA_W-1:0] rec_mdata;
    logic [REC_W-1:0]  rec;

    always_comb begin
        rw   = reg_write_sig && (reg_num != 5'd0);
        mw   = wr;
        mr   = rd;
        gen  = enable && (rw || mw || mr);
        full = (count == CW'(DEPTH));
        pop  = trace_valid && trace_ready;
        push = gen && (!full || pop);
        drop = gen && full && !pop;

        rec_rnum  = '0;
        rec_rdata = '0;
        rec_addr  = '0;
        rec_mdata = '0;
        if (rw) begin
            rec_rnum  = reg_num;
            rec_rdata = reg_data;
        end
        if (mw || mr) begin
            rec_addr  = addr;
            rec_mdata = mw ? wr_data : rd_data;
        end
        rec = {stamp, rw, mw, mr, rec_rnum, rec_addr, rec_rdata, rec_mdata};
    end

    // Head is gated by valid so the output reads 0 whenever the buffer is empty,
    // including straight out of reset; trace_ready never reaches this path.
    assign trace_valid = (count != '0);
    assign trace_data  = trace_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stamp  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            stamp <= stamp + STAMP_W'(1);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer: vector table for record formatting,
// plus sequences for overflow, statistics clear, reset, and pointer/stamp wrap.
module tb_riscv_trace_buffer;

    localparam int REC_W = 97;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             clr_stats;
    logic             reg_write_sig;
    logic [4:0]       reg_num;
    logic [31:0]      reg_data;
    logic             wr;
    logic             rd;
    logic [8:0]       addr;
    logic [31:0]      wr_data;
    logic [31:0]      rd_data;
    logic             trace_valid;
    logic             trace_ready;
    logic [REC_W-1:0] trace_data;
    logic [4:0]       count;
    logic [15:0]      drop_count;
    logic             overflow;

    riscv_trace_buffer #(.DATA_W(32), .DEPTH(16), .STAMP_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clr_stats(clr_stats),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .count(count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles elapsed since the last reset edge.
    logic [15:0] m_stamp;
    always @(posedge clk) begin
        if (reset) m_stamp <= 16'd0;
        else       m_stamp <= m_stamp + 16'd1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        en;
        logic        rws;
        logic [4:0]  rnum;
        logic [31:0] rdata;
        logic        w;
        logic        r;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] rdd;
        logic        gen;
        logic [2:0]  flags;
        logic [4:0]  e_rnum;
        logic [8:0]  e_addr;
        logic [31:0] e_rdata;
        logic [31:0] e_mdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input logic [15:0] s, input logic [2:0] f,
                                                input logic [4:0] rn, input logic [8:0] a,
                                                input logic [31:0] rdv, input logic [31:0] md);
        return {s, f, rn, a, rdv, md};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        enable = 1'b1; clr_stats = 1'b0; reg_write_sig = 1'b0; reg_num = 5'd0;
        reg_data = 32'd0; wr = 1'b0; rd = 1'b0; addr = 9'd0; wr_data = 32'd0; rd_data = 32'd0;
    endtask

    task automatic ev(input logic [4:0] rn, input logic [31:0] d);
        enable = 1'b1; reg_write_sig = 1'b1; reg_num = rn; reg_data = d;
    endtask

    logic [15:0] s0;
    logic [15:0] exp_s;
    int          budget;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 9'h000, 32'h0,        32'h0,
                    1'b1, 3'b100, 5'd5,  9'h000, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 5'd0,  32'h00012345, 1'b0, 1'b0, 9'h044, 32'h0,        32'h0,
                    1'b0, 3'b000, 5'd0,  9'h000, 32'h0,        32'h0};
        vecs[2] = '{1'b1, 1'b1, 5'd7,  32'h00000011, 1'b1, 1'b0, 9'h1A0, 32'h22,       32'h33,
                    1'b1, 3'b110, 5'd7,  9'h1A0, 32'h11,       32'h22};
        vecs[3] = '{1'b1, 1'b0, 5'd9,  32'h0000FFFF, 1'b0, 1'b1, 9'h055, 32'h77,       32'hCAFEF00D,
                    1'b1, 3'b001, 5'd0,  9'h055, 32'h0,        32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b0, 5'd3,  32'h00000001, 1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'h9ABC,
                    1'b1, 3'b011, 5'd0,  9'h1FF, 32'h0,        32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 5'd3,  32'h00000005, 1'b1, 1'b1, 9'h010, 32'h1,        32'h2,
                    1'b0, 3'b000, 5'd0,  9'h000, 32'h0,        32'h0};
        vecs[6] = '{1'b1, 1'b1, 5'd0,  32'h0000AAAA, 1'b0, 1'b1, 9'h100, 32'h0,        32'h5555,
                    1'b1, 3'b001, 5'd0,  9'h100, 32'h0,        32'h5555};
        vecs[7] = '{1'b1, 1'b0, 5'd4,  32'h000000BB, 1'b0, 1'b0, 9'h1AB, 32'hCC,       32'hDD,
                    1'b0, 3'b000, 5'd0,  9'h000, 32'h0,        32'h0};
        vecs[8] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0, 9'h000, 32'h0,        32'h0,
                    1'b1, 3'b110, 5'd31, 9'h000, 32'hFFFFFFFF, 32'h0};

        idle();
        trace_ready = 1'b1;
        reset = 1'b1;
        tick(); tick();
        chk("rst_valid", trace_valid, 1'b0);
        chk("rst_count", count, 5'd0);
        chk("rst_drop", drop_count, 16'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_data", trace_data, '0);
        reset = 1'b0;

        // First vector lands in stamp cycle 3.
        while (m_stamp != 16'd3) tick();

        for (int i = 0; i < 9; i++) begin
            enable = vecs[i].en; reg_write_sig = vecs[i].rws; reg_num = vecs[i].rnum;
            reg_data = vecs[i].rdata; wr = vecs[i].w; rd = vecs[i].r; addr = vecs[i].a;
            wr_data = vecs[i].wd; rd_data = vecs[i].rdd;
            s0 = m_stamp;
            tick();
            idle();
            if (vecs[i].gen) begin
                chk($sformatf("vec%0d_valid", i), trace_valid, 1'b1);
                chk($sformatf("vec%0d_count", i), count, 5'd1);
                chk($sformatf("vec%0d_data", i), trace_data,
                    mk_rec(s0, vecs[i].flags, vecs[i].e_rnum, vecs[i].e_addr,
                           vecs[i].e_rdata, vecs[i].e_mdata));
            end else begin
                chk($sformatf("vec%0d_novalid", i), trace_valid, 1'b0);
                chk($sformatf("vec%0d_count0", i), count, 5'd0);
            end
            tick();
        end
        chk("tbl_drained", trace_valid, 1'b0);

        // Overflow: 20 events with no consumer.
        trace_ready = 1'b0;
        s0 = m_stamp;
        for (int i = 0; i < 20; i++) begin
            ev(5'd1, 32'(i));
            tick();
        end
        idle();
        chk("ovf_count", count, 5'd16);
        chk("ovf_drop", drop_count, 16'd4);
        chk("ovf_flag", overflow, 1'b1);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), trace_valid, 1'b1);
            chk($sformatf("drain%0d_stamp", i), trace_data[96:81], s0 + 16'(i));
            chk($sformatf("drain%0d_rdata", i), trace_data[63:32], 32'(i));
            tick();
        end
        chk("drain_empty", trace_valid, 1'b0);

        // Reset with 9 entries buffered and stats nonzero.
        trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ev(5'd2, 32'(i));
            tick();
        end
        idle();
        chk("pre_rst_count", count, 5'd9);
        chk("pre_rst_drop", drop_count, 16'd4);
        reset = 1'b1;
        tick();
        chk("mid_rst_count", count, 5'd0);
        chk("mid_rst_valid", trace_valid, 1'b0);
        chk("mid_rst_drop", drop_count, 16'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        ev(5'd2, 32'hAB);
        tick();
        idle();
        chk("post_rst_rec", trace_data, mk_rec(16'd0, 3'b100, 5'd2, 9'd0, 32'hAB, 32'd0));
        trace_ready = 1'b1;
        tick();
        chk("post_rst_empty", trace_valid, 1'b0);

        // Statistics clear, including priority over a same-cycle drop.
        trace_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ev(5'd3, 32'(i));
            tick();
        end
        idle();
        chk("clr_pre_drop", drop_count, 16'd1);
        chk("clr_pre_ovf", overflow, 1'b1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_drop", drop_count, 16'd0);
        chk("clr_ovf", overflow, 1'b0);
        ev(5'd3, 32'h99);
        clr_stats = 1'b1;
        tick();
        idle();
        chk("clr_prio_drop", drop_count, 16'd0);
        chk("clr_prio_ovf", overflow, 1'b0);
        chk("clr_prio_count", count, 5'd16);
        ev(5'd3, 32'h98);
        tick();
        idle();
        chk("drop_again", drop_count, 16'd1);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("clr_drained", trace_valid, 1'b0);

        // Streaming while full, across pointer wrap and stamp wrap.
        trace_ready = 1'b0;
        budget = 0;
        while (m_stamp != 16'hFFE0 && budget < 70000) begin
            tick();
            budget++;
        end
        if (m_stamp != 16'hFFE0) begin
            n_checks++;
            n_fail++;
            $display("FAIL stamp_wait: got %h expected %h", m_stamp, 16'hFFE0);
        end
        for (int i = 0; i < 16; i++) begin
            ev(5'd4, 32'(i));
            tick();
        end
        exp_s = 16'hFFE0;
        trace_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ev(5'd4, 32'(i + 16));
            chk($sformatf("stream%0d_count", i), count, 5'd16);
            chk($sformatf("stream%0d_stamp", i), trace_data[96:81], exp_s);
            chk($sformatf("stream%0d_drop", i), drop_count, 16'd1);
            tick();
            exp_s = exp_s + 16'd1;
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tail%0d_valid", i), trace_valid, 1'b1);
            chk($sformatf("tail%0d_stamp", i), trace_data[96:81], exp_s);
            tick();
            exp_s = exp_s + 16'd1;
        end
        chk("tail_empty", trace_valid, 1'b0);
        chk("tail_drop", drop_count, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
